pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have parameter TRAP_PC, default 32'h0000_0100, PC loaded on misaligned target.
REQ-003 SHALL have ports as listed: clk in 1 system clock; rst_n in 1 asynchronous active-low reset.
REQ-004 SHALL have ports as listed: stall in 1 freeze request; br_valid in 1 branch request; br_ready out 1 request accepted when high with br_valid.
REQ-005 SHALL have ports as listed: br_kind in 2 (00 cond, 01 jal, 10 jalr, 11 reserved); br_fu3 in 3 condition code; br_pc in 32 branch instruction address; br_op1/br_op2 in 32 operands; br_imm in 32 sign-extended offset.
REQ-006 SHALL have comparator ports as listed: cmp_en out 1; cmp_fu3 out 3; cmp_op1/cmp_op2 out 32; cmp_re in 1 combinational comparator result.
REQ-007 SHALL have status ports as listed: pc out 32 current fetch PC; flush out 1 pipeline flush pulse; link out 32 br_pc+4 of last accepted jal/jalr; misalign out 1 pulse; illegal out 1 pulse; taken_cnt out 16 saturating taken counter.

Function
REQ-008 FSM states: IDLE, EVAL, REDIRECT; br_ready = 1 only in IDLE with stall=0.
REQ-009 stall=1 SHALL freeze state, pc and all captured registers; pulses SHALL be 0 while stalled.
REQ-010 IDLE, stall=0, no accepted request: pc <= pc+4 each cycle, 32-bit wrap (FFFF_FFFC -> 0000_0000).
REQ-011 Acceptance SHALL capture kind, fu3, pc, op1, op2, imm in one cycle; pc holds; next state EVAL.
REQ-012 EVAL SHALL drive cmp_en=1, cmp_fu3/op1/op2 from captured registers for exactly one cycle; outside EVAL cmp_en=0, other cmp outputs 0.
REQ-013 Taken decision in EVAL: cond -> cmp_re; jal, jalr -> 1; fu3 010/011 with cond -> 0 plus illegal=1 for one cycle; kind 11 -> 0 plus illegal=1.
REQ-014 Targets: cond, jal = cap_pc+cap_imm; jalr = (cap_op1+cap_imm) with bit0 cleared; all modulo 2^32.
REQ-015 EVAL not-taken: pc <= cap_pc+4, next IDLE, no flush.
REQ-016 EVAL taken: register target, next REDIRECT; jal/jalr SHALL update link <= cap_pc+4.
REQ-017 REDIRECT: flush=1 for that cycle; target[1:0]==00 -> pc <= target; else pc <= TRAP_PC and misalign=1; next IDLE.
REQ-018 taken_cnt SHALL increment once per REDIRECT cycle, saturating at 16'hFFFF.
REQ-019 Branch latency: acceptance cycle + EVAL + REDIRECT = 3 cycles to new pc for taken, 2 for not-taken; back-to-back request accepted on first IDLE cycle.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state IDLE, pc=RESET_PC, link=0, taken_cnt=0, all captured registers 0, flush=misalign=illegal=cmp_en=0.
REQ-021 Reset asserted in EVAL or REDIRECT SHALL abandon the branch with no flush or pc update after release; first cycle after release is IDLE.

Structure
REQ-022 Shared package rv_pkg SHALL hold br_kind encodings, fu3 codes (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111) and FSM state typedef.
REQ-023 Comparator SHALL remain external, connected via cmp_* ports; no sub-module required inside pc_seq.

Verification
REQ-024 Reset release, no requests, stall=0 for 4 cycles -> pc 0,4,8,C.
REQ-025 Cond BEQ br_pc=0x40, op1=op2=5, imm=0x20, cmp_re=1 in EVAL -> flush in REDIRECT, pc=0x60, taken_cnt=1.
REQ-026 BNE br_pc=0x40 with cmp_re=0 -> no flush, pc=0x44 after EVAL, taken_cnt unchanged.
REQ-027 jalr op1=0x1001, imm=0x3, br_pc=0x80 -> target 0x1004, pc=0x1004, link=0x84; with imm=0x1 target 0x1002 -> misalign=1, pc=0x100.
REQ-028 stall=1 held 3 cycles during EVAL -> cmp_en stays high, state/pc frozen, result resolved on first unstalled cycle; fu3=010 -> illegal pulse, pc=br_pc+4.
REQ-029 rst_n low mid-REDIRECT -> pc=RESET_PC immediately, no flush after release; taken_cnt preset to FFFF plus one taken branch stays FFFF.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg -- shared encodings for the PC sequencer.
//   br_kind_e  : branch request kind (cond / jal / jalr / reserved)
//   FU3_*      : conditional-branch condition codes seen on br_fu3/cmp_fu3
//   pc_state_e : sequencer FSM state, also exported on the debug port
//   fu3_is_illegal() : true for the two condition codes with no branch meaning
package rv_pkg;

  typedef enum logic [1:0] {
    KIND_COND = 2'b00,
    KIND_JAL  = 2'b01,
    KIND_JALR = 2'b10,
    KIND_RSV  = 2'b11
  } br_kind_e;

  localparam logic [2:0] FU3_BEQ  = 3'b000;
  localparam logic [2:0] FU3_BNE  = 3'b001;
  localparam logic [2:0] FU3_BLT  = 3'b100;
  localparam logic [2:0] FU3_BGE  = 3'b101;
  localparam logic [2:0] FU3_BLTU = 3'b110;
  localparam logic [2:0] FU3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_REDIRECT = 2'd2
  } pc_state_e;

  // 010 and 011 fall in the gap between BNE and BLT.
  function automatic logic fu3_is_illegal(input logic [2:0] fu3);
    return (fu3 == 3'b010) || (fu3 == 3'b011);
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if -- branch request channel into the PC sequencer.
//   br_valid/br_ready : request handshake
//   br_kind, br_fu3   : branch kind and condition code
//   br_pc             : address of the branch instruction
//   br_op1, br_op2    : register operands
//   br_imm            : sign-extended offset
// Handshake: a request transfers on a rising clock edge where br_valid and
// br_ready are both high. br_ready depends only on sequencer state and stall,
// never on br_valid, so the requester may wait for it before raising valid or
// hold valid high; payload must be stable while br_valid is high.
interface pc_seq_if;
  import rv_pkg::*;

  logic        br_valid;
  logic        br_ready;
  br_kind_e    br_kind;
  logic [2:0]  br_fu3;
  logic [31:0] br_pc;
  logic [31:0] br_op1;
  logic [31:0] br_op2;
  logic [31:0] br_imm;

  modport master (
    output br_valid, br_kind, br_fu3, br_pc, br_op1, br_op2, br_imm,
    input  br_ready
  );

  modport slave (
    input  br_valid, br_kind, br_fu3, br_pc, br_op1, br_op2, br_imm,
    output br_ready
  );

endinterface

// File: rtl/pc_seq.sv
// pc_seq -- fetch PC sequencer with a three-step branch resolver.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall               : freezes state, pc and captured registers
//   br (slave)          : branch request channel (see pc_seq_if)
//   cmp_en/fu3/op1/op2  : request to the external comparator, live in EVAL
//   cmp_re              : combinational comparator result
//   pc                  : current fetch PC
//   flush               : one-cycle pulse when a taken branch redirects
//   link                : br_pc+4 of the last taken jal/jalr
//   misalign, illegal   : one-cycle error pulses
//   taken_cnt           : saturating count of redirects
//   dbg_state_o         : current FSM state
// Flow: IDLE accepts a request and captures it (pc holds), EVAL asks the
// comparator and decides, REDIRECT loads the target (or the trap vector).
module pc_seq
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  pc_seq_if.slave     br,
  output logic        cmp_en,
  output logic [2:0]  cmp_fu3,
  output logic [31:0] cmp_op1,
  output logic [31:0] cmp_op2,
  input  logic        cmp_re,
  output logic [31:0] pc,
  output logic        flush,
  output logic [31:0] link,
  output logic        misalign,
  output logic        illegal,
  output logic [15:0] taken_cnt,
  output pc_state_e   dbg_state_o
);

  pc_state_e   state_q, state_d;
  br_kind_e    kind_q, kind_d;
  logic [2:0]  fu3_q, fu3_d;
  logic [31:0] cap_pc_q, cap_pc_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] target_q, target_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] link_q, link_d;
  logic [15:0] cnt_q, cnt_d;

  logic        eval_taken;
  logic        eval_illegal;
  logic [31:0] eval_target;
  logic [31:0] jalr_sum;

  // ---------------------------------------------------------------------
  // Branch decision, meaningful only while in EVAL.
  // ---------------------------------------------------------------------
  assign jalr_sum = op1_q + imm_q;

  always_comb begin
    eval_taken   = 1'b0;
    eval_illegal = 1'b0;
    case (kind_q)
      KIND_COND: begin
        if (fu3_is_illegal(fu3_q)) eval_illegal = 1'b1;
        else                       eval_taken   = cmp_re;
      end
      KIND_JAL,
      KIND_JALR: eval_taken = 1'b1;
      default:   eval_illegal = 1'b1;
    endcase
    // jalr drops bit 0 of the sum; bit 1 is left for the misalign check.
    if (kind_q == KIND_JALR) eval_target = {jalr_sum[31:1], 1'b0};
    else                     eval_target = cap_pc_q + imm_q;
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!stall) begin
      case (state_q)
        ST_IDLE:     if (br.br_valid) state_d = ST_EVAL;
        ST_EVAL:     state_d = eval_taken ? ST_REDIRECT : ST_IDLE;
        ST_REDIRECT: state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Pulses are gated by stall; the comparator request stays
  // up for the whole EVAL residency so a stalled EVAL keeps it asserted.
  // ---------------------------------------------------------------------
  always_comb begin
    br.br_ready = 1'b0;
    cmp_en      = 1'b0;
    cmp_fu3     = 3'b000;
    cmp_op1     = 32'h0;
    cmp_op2     = 32'h0;
    flush       = 1'b0;
    misalign    = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      ST_IDLE: br.br_ready = !stall;
      ST_EVAL: begin
        cmp_en  = 1'b1;
        cmp_fu3 = fu3_q;
        cmp_op1 = op1_q;
        cmp_op2 = op2_q;
        illegal = !stall && eval_illegal;
      end
      ST_REDIRECT: begin
        flush    = !stall;
        misalign = !stall && (target_q[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------
  always_comb begin
    kind_d   = kind_q;
    fu3_d    = fu3_q;
    cap_pc_d = cap_pc_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    imm_d    = imm_q;
    target_d = target_q;
    pc_d     = pc_q;
    link_d   = link_q;
    cnt_d    = cnt_q;
    if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          if (br.br_valid) begin
            // Accepting cycle: capture everything, the fetch PC holds.
            kind_d   = br.br_kind;
            fu3_d    = br.br_fu3;
            cap_pc_d = br.br_pc;
            op1_d    = br.br_op1;
            op2_d    = br.br_op2;
            imm_d    = br.br_imm;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
        ST_EVAL: begin
          if (eval_taken) begin
            target_d = eval_target;
            if (kind_q != KIND_COND) link_d = cap_pc_q + 32'd4;
          end else begin
            pc_d = cap_pc_q + 32'd4;
          end
        end
        ST_REDIRECT: begin
          pc_d = (target_q[1:0] == 2'b00) ? target_q : TRAP_PC;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q   <= KIND_COND;
      fu3_q    <= 3'b000;
      cap_pc_q <= 32'h0;
      op1_q    <= 32'h0;
      op2_q    <= 32'h0;
      imm_q    <= 32'h0;
      target_q <= 32'h0;
      pc_q     <= RESET_PC;
      link_q   <= 32'h0;
      cnt_q    <= 16'h0;
    end else begin
      kind_q   <= kind_d;
      fu3_q    <= fu3_d;
      cap_pc_q <= cap_pc_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      imm_q    <= imm_d;
      target_q <= target_d;
      pc_q     <= pc_d;
      link_q   <= link_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign link        = link_q;
  assign taken_cnt   = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq -- self-checking bench for pc_seq.
// Each branch request pushes the PC it should resolve to onto exp_q; the
// entry is popped when the sequencer returns to IDLE and compared with pc.
// Inputs change right after a falling edge; outputs are sampled 1 ns later.
module tb_pc_seq;
  import rv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRP_PC = 32'h0000_0100;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall;
  logic        cmp_re;
  logic        cmp_en;
  logic [2:0]  cmp_fu3;
  logic [31:0] cmp_op1;
  logic [31:0] cmp_op2;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] link;
  logic        misalign;
  logic        illegal;
  logic [15:0] taken_cnt;
  pc_state_e   dbg_state;

  pc_seq_if br ();

  pc_seq #(.RESET_PC(RST_PC), .TRAP_PC(TRP_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .br          (br),
    .cmp_en      (cmp_en),
    .cmp_fu3     (cmp_fu3),
    .cmp_op1     (cmp_op1),
    .cmp_op2     (cmp_op2),
    .cmp_re      (cmp_re),
    .pc          (pc),
    .flush       (flush),
    .link        (link),
    .misalign    (misalign),
    .illegal     (illegal),
    .taken_cnt   (taken_cnt),
    .dbg_state_o (dbg_state)
  );

  // scoreboard
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_link;
  logic [15:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      br.br_valid = 1'b0;
      stall       = 1'b0;
      @(negedge clk);
      exp_pc = exp_pc + 32'd4;
      #1;
      check("idle_pc", pc, exp_pc);
    end
  endtask

  task automatic stall_idle(input int n);
    br.br_valid = 1'b1;
    br.br_kind  = KIND_JAL;
    br.br_pc    = 32'h0000_0900;
    br.br_imm   = 32'h0000_0010;
    for (int i = 0; i < n; i++) begin
      stall = 1'b1;
      #1;
      check("stall_ready", 32'(br.br_ready), 32'd0);
      @(negedge clk);
      #1;
      check("stall_idle_pc", pc, exp_pc);
      check("stall_idle_st", 32'(dbg_state), 32'(ST_IDLE));
    end
    br.br_valid = 1'b0;
    stall       = 1'b0;
  endtask

  task automatic run_branch(input logic [1:0] kind, input logic [2:0] fu3,
                            input logic [31:0] bpc, input logic [31:0] op1,
                            input logic [31:0] op2, input logic [31:0] imm,
                            input logic re, input int eval_stall);
    logic        ill, taken, mis;
    logic [31:0] tgt, npc;
    ill   = (kind == 2'b11) || (kind == 2'b00 && (fu3 == 3'b010 || fu3 == 3'b011));
    taken = !ill && ((kind != 2'b00) || re);
    tgt   = (kind == 2'b10) ? ((op1 + imm) & 32'hFFFF_FFFE) : (bpc + imm);
    mis   = taken && (tgt[1:0] != 2'b00);
    npc   = !taken ? (bpc + 32'd4) : (mis ? TRP_PC : tgt);
    exp_q.push_back(npc);

    // acceptance cycle
    stall       = 1'b0;
    br.br_valid = 1'b1;
    br.br_kind  = br_kind_e'(kind);
    br.br_fu3   = fu3;
    br.br_pc    = bpc;
    br.br_op1   = op1;
    br.br_op2   = op2;
    br.br_imm   = imm;
    #1;
    check("acc_ready", 32'(br.br_ready), 32'd1);
    check("acc_pc", pc, exp_pc);
    check("acc_cmp_en", 32'(cmp_en), 32'd0);

    // EVAL, optionally stalled
    @(negedge clk);
    br.br_valid = 1'b0;
    br.br_op1   = 32'hDEAD_BEEF;  // captured copy must be used from here on
    cmp_re      = re;
    for (int i = 0; i < eval_stall; i++) begin
      stall = 1'b1;
      #1;
      check("stl_state", 32'(dbg_state), 32'(ST_EVAL));
      check("stl_cmp_en", 32'(cmp_en), 32'd1);
      check("stl_illegal", 32'(illegal), 32'd0);
      check("stl_pc", pc, exp_pc);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    check("ev_state", 32'(dbg_state), 32'(ST_EVAL));
    check("ev_cmp_en", 32'(cmp_en), 32'd1);
    check("ev_cmp_fu3", 32'(cmp_fu3), 32'(fu3));
    check("ev_cmp_op1", cmp_op1, op1);
    check("ev_cmp_op2", cmp_op2, op2);
    check("ev_illegal", 32'(illegal), 32'(ill));
    check("ev_flush", 32'(flush), 32'd0);
    check("ev_pc", pc, exp_pc);

    if (taken) begin
      @(negedge clk);
      #1;
      check("rd_state", 32'(dbg_state), 32'(ST_REDIRECT));
      check("rd_flush", 32'(flush), 32'd1);
      check("rd_misalign", 32'(misalign), 32'(mis));
      check("rd_cmp_en", 32'(cmp_en), 32'd0);
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      if (kind != 2'b00) exp_link = bpc + 32'd4;
    end

    // back in IDLE with the resolved PC
    @(negedge clk);
    cmp_re = 1'b0;
    #1;
    exp_pc = exp_q.pop_front();
    check("res_pc", pc, exp_pc);
    check("res_state", 32'(dbg_state), 32'(ST_IDLE));
    check("res_flush", 32'(flush), 32'd0);
    check("res_link", link, exp_link);
    check("res_cnt", 32'(taken_cnt), 32'(exp_cnt));
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    cmp_re      = 1'b0;
    br.br_valid = 1'b0;
    br.br_kind  = KIND_COND;
    br.br_fu3   = FU3_BEQ;
    br.br_pc    = 32'h0;
    br.br_op1   = 32'h0;
    br.br_op2   = 32'h0;
    br.br_imm   = 32'h0;
    exp_pc      = RST_PC;
    exp_link    = 32'h0;
    exp_cnt     = 16'h0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_link", link, 32'h0);
    check("rst_cnt", 32'(taken_cnt), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_cmp_en", 32'(cmp_en), 32'd0);
    rst_n = 1'b1;
    idle(3);  // 4, 8, C

    // BEQ taken, then BNE not taken
    run_branch(2'b00, FU3_BEQ, 32'h40, 32'd5, 32'd5, 32'h20, 1'b1, 0);
    run_branch(2'b00, FU3_BNE, 32'h40, 32'd5, 32'd5, 32'h20, 1'b0, 0);
    idle(1);
    // jalr aligned and misaligned
    run_branch(2'b10, FU3_BEQ, 32'h80, 32'h1001, 32'h0, 32'h3, 1'b0, 0);
    run_branch(2'b10, FU3_BEQ, 32'h80, 32'h1001, 32'h0, 32'h1, 1'b0, 0);
    // jal with negative offset
    run_branch(2'b01, FU3_BEQ, 32'h200, 32'h0, 32'h0, 32'hFFFF_FFF8, 1'b0, 0);
    // stalled EVAL with illegal fu3, reserved kind, stalled taken BLT
    run_branch(2'b00, 3'b010, 32'h300, 32'h7, 32'h9, 32'h40, 1'b1, 3);
    run_branch(2'b11, FU3_BEQ, 32'h340, 32'h0, 32'h0, 32'h40, 1'b1, 0);
    run_branch(2'b00, FU3_BLT, 32'h400, 32'hFFFF_FFFF, 32'h1, 32'h100, 1'b1, 2);
    // stall in IDLE blocks acceptance and freezes pc
    stall_idle(2);
    idle(1);
    // 32-bit wrap of the sequential PC
    run_branch(2'b01, FU3_BEQ, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFF8, 1'b0, 0);
    idle(2);  // FFFF_FFFC, 0000_0000

    // random mix with random gaps and stalls
    for (int n = 0; n < 10; n++) begin
      logic [1:0]  k;
      logic [2:0]  f;
      logic [31:0] im;
      k  = 2'($urandom_range(0, 2));
      f  = 3'($urandom_range(0, 7));
      if (f == 3'b010 || f == 3'b011) f = FU3_BGEU;
      im = $urandom;
      if ($urandom_range(0, 3) != 0) im[1:0] = 2'b00;
      run_branch(k, f, $urandom & 32'hFFFF_FFFC, $urandom, $urandom, im,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      idle(int'($urandom_range(0, 2)));
    end

    // counter saturation from a preset near the top
    @(negedge clk);
    exp_pc = exp_pc + 32'd4;
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    exp_cnt = 16'hFFFE;
    run_branch(2'b01, FU3_BEQ, 32'h600, 32'h0, 32'h0, 32'h10, 1'b0, 0);
    run_branch(2'b00, FU3_BGE, 32'h700, 32'h3, 32'h3, 32'h20, 1'b1, 0);

    // reset in the middle of REDIRECT abandons the branch
    br.br_valid = 1'b1;
    br.br_kind  = KIND_COND;
    br.br_fu3   = FU3_BEQ;
    br.br_pc    = 32'h500;
    br.br_imm   = 32'h40;
    @(negedge clk);
    br.br_valid = 1'b0;
    cmp_re      = 1'b1;
    @(negedge clk);
    cmp_re = 1'b0;
    #1;
    check("mr_state", 32'(dbg_state), 32'(ST_REDIRECT));
    rst_n = 1'b0;
    #1;
    check("mr_pc", pc, RST_PC);
    check("mr_flush", 32'(flush), 32'd0);
    check("mr_state_rst", 32'(dbg_state), 32'(ST_IDLE));
    check("mr_cnt", 32'(taken_cnt), 32'd0);
    check("mr_link", link, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_rel_pc", pc, RST_PC);
    check("mr_rel_flush", 32'(flush), 32'd0);
    exp_pc   = RST_PC;
    exp_cnt  = 16'h0;
    exp_link = 32'h0;
    @(negedge clk);
    #1;
    check("mr_post_flush", 32'(flush), 32'd0);
    check("mr_post_pc", pc, RST_PC + 32'd4);
    check("mr_post_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_pc = RST_PC + 32'd4;
    idle(1);

    check("q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
